// File: rtl/ola_trigger_match.sv
// Trigger-condition stage behind the OLA edge detector: masked level plus edge match, hit counting, single fire pulse.
// Optional post-match delay is built only when OLA_TRIGGER_MATCH_DELAY_EN is defined.
module ola_trigger_match #(
    parameter int width       = 8,
    parameter int count_width = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    // in_valid qualifies one sample per cycle; there is no ready, this stage always accepts.
    input  logic                   in_valid,
    input  logic [width-1:0]       in_sample,
    input  logic [width-1:0]       in_rising,
    input  logic [width-1:0]       in_falling,
    input  logic [width-1:0]       cfg_value,
    input  logic [width-1:0]       cfg_mask,
    input  logic [width-1:0]       cfg_rise,
    input  logic [width-1:0]       cfg_fall,
    input  logic                   cfg_edge_any,
    input  logic [count_width-1:0] cfg_count,
    input  logic [count_width-1:0] cfg_delay,
    input  logic                   arm,
    input  logic                   abort,
    output logic                   out_armed,
    output logic                   out_fire,
    output logic                   out_triggered,
    output logic [count_width-1:0] out_hits,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DELAY = 2'd2,
        S_FIRED = 2'd3
    } state_t;

    localparam logic [count_width-1:0] one_c = count_width'(1);

    state_t                 state;
    logic [width-1:0]       sh_value;
    logic [width-1:0]       sh_mask;
    logic [width-1:0]       sh_rise;
    logic [width-1:0]       sh_fall;
    logic                   sh_edge_any;
    logic [count_width-1:0] sh_count;

    logic                   level_ok;
    logic                   edge_all_ok;
    logic                   edge_any_ok;
    logic                   hit;
    logic [count_width-1:0] target;
    logic [count_width-1:0] hits_inc;
    logic                   final_hit;

`ifdef OLA_TRIGGER_MATCH_DELAY_EN
    logic [count_width-1:0] sh_delay;
    logic [count_width-1:0] delay_cnt;
    logic [count_width-1:0] delay_next;
    assign delay_next = delay_cnt + one_c;
`else
    logic unused_cfg_delay;
    assign unused_cfg_delay = ^cfg_delay;
`endif

    assign dbg_state = state;

    assign level_ok    = ((in_sample ^ sh_value) & sh_mask) == '0;
    assign edge_all_ok = ((sh_rise & ~in_rising) == '0) && ((sh_fall & ~in_falling) == '0);
    // With no edge required, any mode is satisfied rather than impossible.
    assign edge_any_ok = ((sh_rise | sh_fall) == '0) ||
                         (((sh_rise & in_rising) | (sh_fall & in_falling)) != '0);
    assign hit         = in_valid && level_ok && (sh_edge_any ? edge_any_ok : edge_all_ok);

    assign target    = (sh_count == '0) ? one_c : sh_count;
    assign hits_inc  = (out_hits == '1) ? out_hits : out_hits + one_c;
    assign final_hit = (hits_inc == target);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            out_armed     <= 1'b0;
            out_fire      <= 1'b0;
            out_triggered <= 1'b0;
            out_hits      <= '0;
            sh_value      <= '0;
            sh_mask       <= '0;
            sh_rise       <= '0;
            sh_fall       <= '0;
            sh_edge_any   <= 1'b0;
            sh_count      <= '0;
`ifdef OLA_TRIGGER_MATCH_DELAY_EN
            sh_delay      <= '0;
            delay_cnt     <= '0;
`endif
        end else begin
            out_fire <= 1'b0;
            if (abort) begin
                state         <= S_IDLE;
                out_armed     <= 1'b0;
                out_triggered <= 1'b0;
                out_hits      <= '0;
`ifdef OLA_TRIGGER_MATCH_DELAY_EN
                delay_cnt     <= '0;
`endif
            end else if (arm) begin
                state         <= S_ARMED;
                out_armed     <= 1'b1;
                out_triggered <= 1'b0;
                out_hits      <= '0;
                sh_value      <= cfg_value;
                sh_mask       <= cfg_mask;
                sh_rise       <= cfg_rise;
                sh_fall       <= cfg_fall;
                sh_edge_any   <= cfg_edge_any;
                sh_count      <= cfg_count;
`ifdef OLA_TRIGGER_MATCH_DELAY_EN
                sh_delay      <= cfg_delay;
                delay_cnt     <= '0;
`endif
            end else begin
                case (state)
                    S_ARMED: begin
                        if (hit) begin
                            out_hits <= hits_inc;
                            if (final_hit) begin
`ifdef OLA_TRIGGER_MATCH_DELAY_EN
                                if (sh_delay != '0) begin
                                    state <= S_DELAY;
                                end else begin
                                    state         <= S_FIRED;
                                    out_armed     <= 1'b0;
                                    out_fire      <= 1'b1;
                                    out_triggered <= 1'b1;
                                end
`else
                                state         <= S_FIRED;
                                out_armed     <= 1'b0;
                                out_fire      <= 1'b1;
                                out_triggered <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef OLA_TRIGGER_MATCH_DELAY_EN
                    S_DELAY: begin
                        if (in_valid) begin
                            delay_cnt <= delay_next;
                            if (delay_next == sh_delay) begin
                                state         <= S_FIRED;
                                out_armed     <= 1'b0;
                                out_fire      <= 1'b1;
                                out_triggered <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ola_trigger_match.sv
// Table-driven bench for ola_trigger_match with a scoreboard queue of expected {armed, fire, triggered, hits}.
module tb_ola_trigger_match;

    localparam int W  = 8;
    localparam int CW = 16;
    localparam int EW = CW + 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_sample = '0;
    logic [W-1:0]  in_rising = '0;
    logic [W-1:0]  in_falling = '0;
    logic [W-1:0]  cfg_value = '0;
    logic [W-1:0]  cfg_mask = '0;
    logic [W-1:0]  cfg_rise = '0;
    logic [W-1:0]  cfg_fall = '0;
    logic          cfg_edge_any = 1'b0;
    logic [CW-1:0] cfg_count = '0;
    logic [CW-1:0] cfg_delay = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          out_armed;
    logic          out_fire;
    logic          out_triggered;
    logic [CW-1:0] out_hits;
    logic [1:0]    dbg_state;

    ola_trigger_match #(.width(W), .count_width(CW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_sample(in_sample),
        .in_rising(in_rising), .in_falling(in_falling), .cfg_value(cfg_value),
        .cfg_mask(cfg_mask), .cfg_rise(cfg_rise), .cfg_fall(cfg_fall),
        .cfg_edge_any(cfg_edge_any), .cfg_count(cfg_count), .cfg_delay(cfg_delay),
        .arm(arm), .abort(abort), .out_armed(out_armed), .out_fire(out_fire),
        .out_triggered(out_triggered), .out_hits(out_hits), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          arm;
        logic          abort;
        logic          valid;
        logic [W-1:0]  sample;
        logic [W-1:0]  rising;
        logic [W-1:0]  falling;
        logic [W-1:0]  value;
        logic [W-1:0]  mask;
        logic [W-1:0]  rise;
        logic [W-1:0]  fall;
        logic          any;
        logic [CW-1:0] count;
        logic [EW-1:0] exp;
    } vec_t;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    function automatic logic [EW-1:0] e(input logic a, input logic f, input logic t,
                                        input logic [CW-1:0] h);
        return {a, f, t, h};
    endfunction

    function automatic vec_t mk(input logic a, input logic ab, input logic v,
                                input logic [W-1:0] s, input logic [W-1:0] r,
                                input logic [W-1:0] f, input logic [W-1:0] val,
                                input logic [W-1:0] m, input logic [W-1:0] ri,
                                input logic [W-1:0] fa, input logic an,
                                input logic [CW-1:0] c, input logic [EW-1:0] ex);
        vec_t x;
        x.arm = a; x.abort = ab; x.valid = v; x.sample = s; x.rising = r; x.falling = f;
        x.value = val; x.mask = m; x.rise = ri; x.fall = fa; x.any = an; x.count = c;
        x.exp = ex;
        return x;
    endfunction

    // data row: config inputs driven to zero, they must be ignored while armed
    function automatic vec_t dv(input logic v, input logic [W-1:0] s, input logic [W-1:0] r,
                                input logic [W-1:0] f, input logic [EW-1:0] ex);
        return mk(1'b0, 1'b0, v, s, r, f, '0, '0, '0, '0, 1'b0, '0, ex);
    endfunction

    // arm row: a valid sample matching the new config rides along and must not count
    function automatic vec_t ar(input logic [W-1:0] val, input logic [W-1:0] m,
                                input logic [W-1:0] ri, input logic [W-1:0] fa,
                                input logic an, input logic [CW-1:0] c);
        return mk(1'b1, 1'b0, 1'b1, val, ri, fa, val, m, ri, fa, an, c, e(1, 0, 0, 0));
    endfunction

    // scoreboard
    function automatic logic [EW-1:0] got_now();
        return {out_armed, out_fire, out_triggered, out_hits};
    endfunction

    task automatic compare(input string name);
        logic [EW-1:0] want;
        logic [EW-1:0] got;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            want = exp_q.pop_front();
            got  = got_now();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got armed=%b fire=%b trig=%b hits=%h, want armed=%b fire=%b trig=%b hits=%h",
                         name, got[EW-1], got[EW-2], got[EW-3], got[CW-1:0],
                         want[EW-1], want[EW-2], want[EW-3], want[CW-1:0]);
            end
        end
    endtask

    task automatic check_now(input logic [EW-1:0] ex, input string name);
        exp_q.push_back(ex);
        compare(name);
    endtask

    // drivers
    task automatic drive(input vec_t v);
        arm = v.arm; abort = v.abort; in_valid = v.valid; in_sample = v.sample;
        in_rising = v.rising; in_falling = v.falling; cfg_value = v.value;
        cfg_mask = v.mask; cfg_rise = v.rise; cfg_fall = v.fall;
        cfg_edge_any = v.any; cfg_count = v.count;
    endtask

    task automatic apply(input vec_t v, input string name);
        drive(v);
        exp_q.push_back(v.exp);
        @(posedge clock);
        #1;
        compare(name);
    endtask

    task automatic step_raw(input vec_t v);
        drive(v);
        @(posedge clock);
        #1;
    endtask

    initial begin
        // reset
        #1;
        check_now(e(0, 0, 0, 0), "reset_outputs");
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        apply(dv(1, 8'hA5, '0, '0, e(0, 0, 0, 0)), "idle_no_count");

        // level trigger
        tbl.push_back(ar(8'hA5, 8'hFF, 8'h00, 8'h00, 0, 16'd1));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 0)));
        tbl.push_back(dv(1, 8'hA5, 8'h00, 8'h00, e(0, 1, 1, 1)));
        tbl.push_back(dv(0, 8'h00, 8'h00, 8'h00, e(0, 0, 1, 1)));
        tbl.push_back(dv(1, 8'hA5, 8'h00, 8'h00, e(0, 0, 1, 1)));
        // edge, all mode
        tbl.push_back(ar(8'h00, 8'h00, 8'h03, 8'h00, 0, 16'd1));
        tbl.push_back(dv(1, 8'h00, 8'h01, 8'h00, e(1, 0, 0, 0)));
        tbl.push_back(dv(1, 8'h00, 8'h03, 8'h00, e(0, 1, 1, 1)));
        // falling, all mode
        tbl.push_back(ar(8'h00, 8'h00, 8'h00, 8'h80, 0, 16'd1));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h40, e(1, 0, 0, 0)));
        tbl.push_back(dv(1, 8'h00, 8'hFF, 8'h80, e(0, 1, 1, 1)));
        // edge, any mode
        tbl.push_back(ar(8'h00, 8'h00, 8'h03, 8'h00, 1, 16'd1));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 0)));
        tbl.push_back(dv(1, 8'h00, 8'h04, 8'h00, e(1, 0, 0, 0)));
        tbl.push_back(dv(1, 8'h00, 8'h02, 8'h00, e(0, 1, 1, 1)));
        // any mode with no edge required
        tbl.push_back(ar(8'h00, 8'h00, 8'h00, 8'h00, 1, 16'd1));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(0, 1, 1, 1)));
        // hit count 3 with in_valid toggling
        tbl.push_back(ar(8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd3));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)));
        tbl.push_back(dv(0, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 2)));
        tbl.push_back(dv(0, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 2)));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(0, 1, 1, 3)));
        tbl.push_back(dv(0, 8'h00, 8'h00, 8'h00, e(0, 0, 1, 3)));
        // count 0 reads as 1
        tbl.push_back(ar(8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd0));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(0, 1, 1, 1)));
        // config latched at arm only
        tbl.push_back(ar(8'h11, 8'hFF, 8'h00, 8'h00, 0, 16'd1));
        tbl.push_back(dv(1, 8'h22, 8'h00, 8'h00, e(1, 0, 0, 0)));
        tbl.push_back(dv(1, 8'h11, 8'h00, 8'h00, e(0, 1, 1, 1)));
        // abort from ARMED
        tbl.push_back(ar(8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd3));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)));
        tbl.push_back(mk(0, 1, 1, '0, '0, '0, '0, '0, '0, '0, 0, '0, e(0, 0, 0, 0)));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(0, 0, 0, 0)));
        // abort beats arm from FIRED
        tbl.push_back(ar(8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd1));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(0, 1, 1, 1)));
        tbl.push_back(mk(1, 1, 1, '0, '0, '0, '0, '0, '0, '0, 0, 16'd1, e(0, 0, 0, 0)));
        // re-arm while ARMED restarts the count
        tbl.push_back(ar(8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd3));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 2)));
        tbl.push_back(ar(8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd3));
        tbl.push_back(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // post-match delay of 4 valid samples; hits during DELAY are ignored
        cfg_delay = 16'd4;
        apply(ar(8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd1), "dly_arm");
`ifdef OLA_TRIGGER_MATCH_DELAY_EN
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)), "dly_hit");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)), "dly_v1");
        apply(dv(0, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)), "dly_gap");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)), "dly_v2");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)), "dly_v3");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(0, 1, 1, 1)), "dly_v4_fire");
        apply(dv(0, 8'h00, 8'h00, 8'h00, e(0, 0, 1, 1)), "dly_after");
`else
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(0, 1, 1, 1)), "dly_off_fire");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(0, 0, 1, 1)), "dly_off_after");
`endif

        // arm and abort together while waiting out the delay
        apply(ar(8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd1), "race_arm");
`ifdef OLA_TRIGGER_MATCH_DELAY_EN
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)), "race_hit");
`else
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(0, 1, 1, 1)), "race_hit");
`endif
        apply(mk(1, 1, 1, '0, '0, '0, '0, '0, '0, '0, 0, 16'd1, e(0, 0, 0, 0)), "race_abort");
        for (int i = 0; i < 5; i++) begin
            apply(dv(1, 8'h00, 8'h00, 8'h00, e(0, 0, 0, 0)), $sformatf("race_quiet%0d", i));
        end
        cfg_delay = '0;

        // asynchronous reset in the middle of a count
        apply(ar(8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd5), "rst_arm");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 1)), "rst_h1");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(1, 0, 0, 2)), "rst_h2");
        #2;
        reset = 1'b0;
        #1;
        check_now(e(0, 0, 0, 0), "rst_async");
        @(posedge clock); #1;
        reset = 1'b1;
        check_now(e(0, 0, 0, 0), "rst_release");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(0, 0, 0, 0)), "rst_idle1");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(0, 0, 0, 0)), "rst_idle2");
        apply(ar(8'h00, 8'h00, 8'h00, 8'h00, 0, 16'd1), "rst_rearm");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(0, 1, 1, 1)), "rst_fire");

        // full-scale count: fire on reaching all-ones
        apply(ar(8'h00, 8'h00, 8'h00, 8'h00, 0, 16'hFFFF), "sat_arm");
        for (int i = 0; i < 65534; i++) begin
            step_raw(dv(1, 8'h00, 8'h00, 8'h00, e(0, 0, 0, 0)));
        end
        check_now(e(1, 0, 0, 16'hFFFE), "sat_before");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(0, 1, 1, 16'hFFFF)), "sat_fire");
        apply(dv(1, 8'h00, 8'h00, 8'h00, e(0, 0, 1, 16'hFFFF)), "sat_hold");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
